// File: rtl/centroid_pkg.sv
// Shared constants and FSM state type for the target centroid block.
package centroid_pkg;
    localparam int X_W   = 10;
    localparam int Y_W   = 10;
    localparam int SUM_W = 28;
    localparam int CNT_W = 19;

    typedef enum logic [1:0] {
        IDLE,
        DIV_X,
        DIV_Y,
        DONE
    } state_t;
endpackage

// File: rtl/target_centroid_if.sv
// Pixel stream in / centroid result out bundle for target_centroid.
interface target_centroid_if;
    import centroid_pkg::*;

    logic             href_in;
    logic             vsync_in;
    logic             de_in;
    logic             bin_in;
    logic             obj_valid;
    logic             obj_found;
    logic [X_W-1:0]   cx;
    logic [Y_W-1:0]   cy;
    logic [CNT_W-1:0] pix_cnt;
    logic [X_W-1:0]   x_min;
    logic [X_W-1:0]   x_max;
    logic [Y_W-1:0]   y_min;
    logic [Y_W-1:0]   y_max;
    logic             busy;

    modport master (
        output href_in, vsync_in, de_in, bin_in,
        input  obj_valid, obj_found, cx, cy, pix_cnt,
        input  x_min, x_max, y_min, y_max, busy
    );

    modport slave (
        input  href_in, vsync_in, de_in, bin_in,
        output obj_valid, obj_found, cx, cy, pix_cnt,
        output x_min, x_max, y_min, y_max, busy
    );
endinterface

// File: rtl/centroid_div.sv
// Serial restoring divider: one quotient bit per cycle, SUM_W cycles.
// The start cycle performs the first step; a start overrides any
// division in progress. done is high during the cycle of the last step,
// so quotient is final in the cycle after done.
module centroid_div
    import centroid_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [SUM_W-1:0] dividend,
    input  logic [CNT_W-1:0] divisor,
    output logic             done,
    output logic [SUM_W-1:0] quotient
);
    logic [SUM_W-1:0] dvd_q;
    logic [CNT_W-1:0] dsr_q;
    logic [CNT_W-1:0] rem_q;
    logic [4:0]       steps_q;

    logic [SUM_W-1:0] dvd_src;
    logic [SUM_W-1:0] quo_src;
    logic [CNT_W-1:0] dsr_src;
    logic [CNT_W-1:0] rem_src;
    logic [CNT_W:0]   rem_sh;
    logic [CNT_W-1:0] rem_diff;
    logic             ge;
    logic             step;

    // Select fresh operands on start, otherwise continue the running division.
    always_comb begin
        dvd_src  = start ? dividend : dvd_q;
        quo_src  = start ? '0       : quotient;
        dsr_src  = start ? divisor  : dsr_q;
        rem_src  = start ? '0       : rem_q;
        rem_sh   = {rem_src, dvd_src[SUM_W-1]};
        ge       = rem_sh >= {1'b0, dsr_src};
        rem_diff = rem_sh[CNT_W-1:0] - dsr_src;
        step     = start || (steps_q != 5'd0);
        done     = !start && (steps_q == 5'd1);
    end

    // One shift-compare-subtract step per cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dvd_q    <= '0;
            dsr_q    <= '0;
            rem_q    <= '0;
            steps_q  <= '0;
            quotient <= '0;
        end else if (step) begin
            dvd_q    <= {dvd_src[SUM_W-2:0], 1'b0};
            dsr_q    <= dsr_src;
            rem_q    <= ge ? rem_diff : rem_sh[CNT_W-1:0];
            quotient <= {quo_src[SUM_W-2:0], ge};
            steps_q  <= start ? 5'(SUM_W - 1) : steps_q - 5'd1;
        end
    end
endmodule

// File: rtl/target_centroid.sv
// Per-frame object centroid: accumulates coordinate sums of object pixels
// and divides them by the pixel count at each vsync rising edge.
// Optional bounding box trackers: define CENTROID_BBOX_EN.
module target_centroid
    import centroid_pkg::*;
#(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int MIN_PIXELS = 16
) (
    input logic              clk,
    input logic              rst_n,
    target_centroid_if.slave io
);
    localparam logic [X_W-1:0]   X_LAST  = X_W'(IMG_WIDTH - 1);
    localparam logic [Y_W-1:0]   Y_LAST  = Y_W'(IMG_HEIGHT - 1);
    localparam logic [CNT_W-1:0] MIN_CNT = CNT_W'(MIN_PIXELS);

    logic             href_d, vsync_d;
    logic             href_fall, vsync_rise, boundary, hit;
    logic [X_W-1:0]   x_cnt;
    logic [Y_W-1:0]   y_cnt;
    logic [SUM_W-1:0] sum_x, sum_y, snap_sx, snap_sy;
    logic [CNT_W-1:0] cnt, snap_cnt;
    logic             snap_found, first_q;
    state_t           state, state_nx;
    logic             start_q, start_nx;
    logic             div_done;
    logic [SUM_W-1:0] quotient;
    logic [X_W-1:0]   cx_res, q_clamp;

    assign href_fall  = href_d && !io.href_in;
    assign vsync_rise = io.vsync_in && !vsync_d;
    assign boundary   = vsync_rise && !first_q;
    assign hit        = io.de_in && io.bin_in;
    assign io.busy    = (state != IDLE);
    // Mean coordinates always fit the column range; saturation only guards.
    assign q_clamp    = (|quotient[SUM_W-1:X_W]) ? '1 : quotient[X_W-1:0];

    // Input edge detection and pixel position counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            href_d  <= 1'b0;
            vsync_d <= 1'b0;
            x_cnt   <= '0;
            y_cnt   <= '0;
        end else begin
            href_d  <= io.href_in;
            vsync_d <= io.vsync_in;
            if (vsync_rise || href_fall) x_cnt <= '0;
            else if (io.de_in && x_cnt != X_LAST) x_cnt <= x_cnt + 1'b1;
            if (vsync_rise) y_cnt <= '0;
            else if (href_fall && y_cnt != Y_LAST) y_cnt <= y_cnt + 1'b1;
        end
    end

    // Accumulators and frame-boundary snapshot; a pixel on the boundary
    // cycle seeds the new frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_x      <= '0;
            sum_y      <= '0;
            cnt        <= '0;
            snap_sx    <= '0;
            snap_sy    <= '0;
            snap_cnt   <= '0;
            snap_found <= 1'b0;
            first_q    <= 1'b1;
        end else if (vsync_rise) begin
            snap_sx    <= sum_x;
            snap_sy    <= sum_y;
            snap_cnt   <= cnt;
            snap_found <= (cnt >= MIN_CNT) && (cnt != '0);
            first_q    <= 1'b0;
            sum_x      <= hit ? SUM_W'(x_cnt) : '0;
            sum_y      <= hit ? SUM_W'(y_cnt) : '0;
            cnt        <= hit ? CNT_W'(1) : '0;
        end else if (hit) begin
            sum_x <= sum_x + SUM_W'(x_cnt);
            sum_y <= sum_y + SUM_W'(y_cnt);
            cnt   <= cnt + 1'b1;
        end
    end

    // FSM state register and divider start pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            start_q <= 1'b0;
        end else begin
            state   <= state_nx;
            start_q <= start_nx;
        end
    end

    // Next state: a boundary always restarts; a stale done is ignored on start.
    always_comb begin
        state_nx = state;
        start_nx = 1'b0;
        if (boundary) begin
            if ((cnt >= MIN_CNT) && (cnt != '0)) begin
                state_nx = DIV_X;
                start_nx = 1'b1;
            end else begin
                state_nx = DONE;
            end
        end else begin
            case (state)
                IDLE: state_nx = IDLE;
                DIV_X: if (!start_q && div_done) begin
                    state_nx = DIV_Y;
                    start_nx = 1'b1;
                end
                DIV_Y: if (!start_q && div_done) state_nx = DONE;
                DONE:  state_nx = IDLE;
                default: state_nx = IDLE;
            endcase
        end
    end

    centroid_div u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start_q),
        .dividend ((state == DIV_Y) ? snap_sy : snap_sx),
        .divisor  (snap_cnt),
        .done     (div_done),
        .quotient (quotient)
    );

    // Result registers, updated together with the obj_valid pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cx_res       <= '0;
            io.obj_valid <= 1'b0;
            io.obj_found <= 1'b0;
            io.cx        <= '0;
            io.cy        <= '0;
            io.pix_cnt   <= '0;
        end else begin
            if (state == DIV_Y && start_q) cx_res <= q_clamp;
            io.obj_valid <= 1'b0;
            if (state == DONE && !boundary) begin
                io.obj_valid <= 1'b1;
                io.obj_found <= snap_found;
                io.pix_cnt   <= snap_cnt;
                io.cx        <= snap_found ? cx_res : '0;
                io.cy        <= snap_found ? Y_W'(q_clamp) : '0;
            end
        end
    end

`ifdef CENTROID_BBOX_EN
    logic [X_W-1:0] bx_min, bx_max, sx_min, sx_max, ox_min, ox_max;
    logic [Y_W-1:0] by_min, by_max, sy_min, sy_max, oy_min, oy_max;

    // Per-frame box trackers, snapshotted at the boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bx_min <= '1; bx_max <= '0; by_min <= '1; by_max <= '0;
            sx_min <= '0; sx_max <= '0; sy_min <= '0; sy_max <= '0;
        end else if (vsync_rise) begin
            sx_min <= bx_min; sx_max <= bx_max;
            sy_min <= by_min; sy_max <= by_max;
            bx_min <= hit ? x_cnt : '1;
            bx_max <= hit ? x_cnt : '0;
            by_min <= hit ? y_cnt : '1;
            by_max <= hit ? y_cnt : '0;
        end else if (hit) begin
            if (x_cnt < bx_min) bx_min <= x_cnt;
            if (x_cnt > bx_max) bx_max <= x_cnt;
            if (y_cnt < by_min) by_min <= y_cnt;
            if (y_cnt > by_max) by_max <= y_cnt;
        end
    end

    // Box outputs follow the same DONE update as the centroid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ox_min <= '0; ox_max <= '0; oy_min <= '0; oy_max <= '0;
        end else if (state == DONE && !boundary) begin
            ox_min <= snap_found ? sx_min : '0;
            ox_max <= snap_found ? sx_max : '0;
            oy_min <= snap_found ? sy_min : '0;
            oy_max <= snap_found ? sy_max : '0;
        end
    end

    assign io.x_min = ox_min;
    assign io.x_max = ox_max;
    assign io.y_min = oy_min;
    assign io.y_max = oy_max;
`else
    assign io.x_min = '0;
    assign io.x_max = '0;
    assign io.y_min = '0;
    assign io.y_max = '0;
`endif
endmodule
